// File: rtl/scan_buf_ctrl.sv
// scan_buf_ctrl: round-robin sequencer between a write word source and a read host in front of
// a serial-in/parallel-out 256 B buffer. Optional watchdog enabled by SCAN_BUF_WDT_EN.
module scan_buf_ctrl #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WORD_W      = 32
`ifdef SCAN_BUF_WDT_EN
  , parameter int unsigned TIMEOUT_CYC = 200
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_val,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_rdy,
  input  logic              rd_val,
  output logic              rd_rdy,
  output logic              rd_resp_val,
  output logic [WORD_W-1:0] rd_resp_data,
  output logic              buf_val_op,
  output logic              buf_op,
  output logic              buf_sin,
  input  logic              buf_op_ack,
  input  logic              buf_op_commit,
  input  logic [WORD_W-1:0] buf_pout,
  output logic [6:0]        count,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam logic [6:0] DEPTH_C = 7'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAST_BIT_C = CNT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_SHIFT  = 3'd2,
    S_COMMIT = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e            state_q;
  logic              op_q;
  logic              last_rd_q;
  logic              val_op_q;
  logic              sin_q;
  logic [WORD_W-1:0] shr_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [6:0]        count_q;
  logic              resp_val_q;
  logic [WORD_W-1:0] resp_data_q;

  logic wr_elig_s;
  logic rd_elig_s;
  logic grant_wr_s;
  logic grant_rd_s;

`ifdef SCAN_BUF_WDT_EN
  localparam logic [7:0] WDT_LAST_C = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wdt_q;
  logic       err_q;
`endif

  // Round-robin grant: on contention the side not served last wins.
  always_comb begin
    wr_elig_s  = 1'b0;
    rd_elig_s  = 1'b0;
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    if (state_q == S_IDLE) begin
      wr_elig_s  = wr_val && (count_q != DEPTH_C);
      rd_elig_s  = rd_val && (count_q != 7'd0);
      grant_wr_s = wr_elig_s && (!rd_elig_s || last_rd_q);
      grant_rd_s = rd_elig_s && (!wr_elig_s || !last_rd_q);
    end else begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end
  end

  // Sequencer: one buffer operation in flight, outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      last_rd_q   <= 1'b1;
      val_op_q    <= 1'b0;
      sin_q       <= 1'b0;
      shr_q       <= '0;
      bit_cnt_q   <= '0;
      count_q     <= 7'd0;
      resp_val_q  <= 1'b0;
      resp_data_q <= '0;
`ifdef SCAN_BUF_WDT_EN
      wdt_q       <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_wr_s) begin
            op_q      <= 1'b0;
            shr_q     <= wr_data;
            last_rd_q <= 1'b0;
            val_op_q  <= 1'b1;
            state_q   <= S_REQ;
          end else if (grant_rd_s) begin
            op_q      <= 1'b1;
            last_rd_q <= 1'b1;
            val_op_q  <= 1'b1;
            state_q   <= S_REQ;
          end
`ifdef SCAN_BUF_WDT_EN
          wdt_q <= 8'd0;
`endif
        end
        S_REQ: begin
          if (buf_op_ack) begin
            val_op_q <= 1'b0;
`ifdef SCAN_BUF_WDT_EN
            wdt_q    <= 8'd0;
`endif
            if (!op_q) begin
              // First serial bit is presented in the first SHIFT cycle.
              sin_q     <= shr_q[0];
              shr_q     <= {1'b0, shr_q[WORD_W-1:1]};
              bit_cnt_q <= '0;
              state_q   <= S_SHIFT;
            end else begin
              state_q <= S_COMMIT;
            end
          end
`ifdef SCAN_BUF_WDT_EN
          else if (wdt_q == WDT_LAST_C) begin
            err_q    <= 1'b1;
            val_op_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            wdt_q <= wdt_q + 8'd1;
          end
`endif
        end
        S_SHIFT: begin
          if (bit_cnt_q == LAST_BIT_C) begin
            sin_q   <= 1'b0;
            state_q <= S_COMMIT;
          end else begin
            sin_q     <= shr_q[0];
            shr_q     <= {1'b0, shr_q[WORD_W-1:1]};
            bit_cnt_q <= bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_COMMIT: begin
          if (buf_op_commit) begin
            if (!op_q) begin
              count_q <= count_q + 7'd1;
              state_q <= S_IDLE;
            end else begin
              resp_data_q <= buf_pout;
              resp_val_q  <= 1'b1;
              count_q     <= count_q - 7'd1;
              state_q     <= S_RESP;
            end
          end
`ifdef SCAN_BUF_WDT_EN
          else if (wdt_q == WDT_LAST_C) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wdt_q <= wdt_q + 8'd1;
          end
`endif
        end
        S_RESP: begin
          resp_val_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          val_op_q   <= 1'b0;
          sin_q      <= 1'b0;
          resp_val_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_rdy       = grant_wr_s;
  assign rd_rdy       = grant_rd_s;
  assign rd_resp_val  = resp_val_q;
  assign rd_resp_data = resp_data_q;
  assign buf_val_op   = val_op_q;
  assign buf_op       = op_q;
  assign buf_sin      = sin_q;
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == 7'd0);
  assign busy         = (state_q != S_IDLE);
`ifdef SCAN_BUF_WDT_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_scan_buf_ctrl.sv
// Directed bench for scan_buf_ctrl with a behavioural serial-in buffer model.
module tb_scan_buf_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_val, rd_val;
  logic [31:0] wr_data;
  logic        wr_rdy, rd_rdy, rd_resp_val;
  logic [31:0] rd_resp_data;
  logic        buf_val_op, buf_op, buf_sin, buf_op_ack, buf_op_commit;
  logic [31:0] buf_pout;
  logic [6:0]  count;
  logic        full, empty, busy, err;
  logic        ack_en;

  int checks = 0;
  int failures = 0;

  // Buffer model state
  logic [31:0] mem [0:63];
  logic [5:0]  wp, rp;
  logic        coll, rd_pend;
  int          nb;
  logic [31:0] sh, sin_hist, last_word;

  scan_buf_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .wr_val(wr_val), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_val(rd_val), .rd_rdy(rd_rdy),
    .rd_resp_val(rd_resp_val), .rd_resp_data(rd_resp_data),
    .buf_val_op(buf_val_op), .buf_op(buf_op), .buf_sin(buf_sin),
    .buf_op_ack(buf_op_ack), .buf_op_commit(buf_op_commit), .buf_pout(buf_pout),
    .count(count), .full(full), .empty(empty), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  assign buf_op_ack    = ack_en & buf_val_op;
  assign buf_op_commit = 1'b1;
  assign buf_pout      = mem[rp];

  // Buffer model: collects 32 serial bits LSB-first after a write ack, pops on read commit.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= 6'd0; rp <= 6'd0; coll <= 1'b0; nb <= 0; rd_pend <= 1'b0;
    end else begin
      if (coll) begin
        sh[nb]       <= buf_sin;
        sin_hist[nb] <= buf_sin;
        nb           <= nb + 1;
        if (nb == 31) begin
          mem[wp]   <= {buf_sin, sh[30:0]};
          last_word <= {buf_sin, sh[30:0]};
          wp        <= wp + 6'd1;
          coll      <= 1'b0;
        end
      end
      if (buf_val_op && buf_op_ack && !buf_op) begin
        coll <= 1'b1;
        nb   <= 0;
      end
      if (buf_val_op && buf_op_ack && buf_op) rd_pend <= 1'b1;
      if (rd_pend) begin
        rp      <= rp + 6'd1;
        rd_pend <= 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wr_val = 1'b0; rd_val = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_valop"}, 32'(buf_val_op), 32'd0);
    check_val({tag, "_op"}, 32'(buf_op), 32'd0);
    check_val({tag, "_sin"}, 32'(buf_sin), 32'd0);
    check_val({tag, "_count"}, 32'(count), 32'd0);
    check_val({tag, "_empty"}, 32'(empty), 32'd1);
    check_val({tag, "_full"}, 32'(full), 32'd0);
    check_val({tag, "_respv"}, 32'(rd_resp_val), 32'd0);
    check_val({tag, "_respd"}, rd_resp_data, 32'd0);
    check_val({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Called at a negedge with the controller idle.
  task automatic do_write(input logic [31:0] w, input string tag);
    int n;
    int k;
    logic [6:0] c0;
    c0 = count;
    wr_val = 1'b1; wr_data = w;
    #1;
    n = 0;
    while (!wr_rdy && n < 200) begin @(negedge clk); n++; end
    check_val({tag, "_wrdy"}, 32'(wr_rdy), 32'd1);
    @(negedge clk);
    wr_val = 1'b0;
    k = 1;
    while (busy && k < 400) begin
      if (k == 34) check_val({tag, "_cnt_pre"}, 32'(count), 32'(c0));
      @(negedge clk);
      k++;
    end
    check_val({tag, "_lat"}, k, 32'd35);
    check_val({tag, "_cnt"}, 32'(count), 32'(c0) + 32'd1);
    check_val({tag, "_word"}, last_word, w);
  endtask

  task automatic do_read(input logic [31:0] exp, input string tag);
    int n;
    int k;
    rd_val = 1'b1;
    #1;
    n = 0;
    while (!rd_rdy && n < 200) begin @(negedge clk); n++; end
    check_val({tag, "_rrdy"}, 32'(rd_rdy), 32'd1);
    @(negedge clk);
    rd_val = 1'b0;
    k = 1;
    while (!rd_resp_val && k < 50) begin @(negedge clk); k++; end
    check_val({tag, "_lat"}, k, 32'd3);
    check_val({tag, "_data"}, rd_resp_data, exp);
    @(negedge clk);
    check_val({tag, "_pulse"}, 32'(rd_resp_val), 32'd0);
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int exp_b [10] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    int n;
    int gi;
    int ri;
    logic g [4];
    logic [31:0] rdata [4];

    ack_en = 1'b1;
    wr_data = 32'd0;
    do_reset();
    check_reset_outputs("rst");

    // 1: single write, bit order on sin
    do_write(32'h07020106, "t1");
    for (int i = 0; i < 10; i++)
      check_val($sformatf("t1_sin%0d", i), 32'(sin_hist[i]), 32'(exp_b[i]));
    check_val("t1_empty", 32'(empty), 32'd0);

    // 2: four writes then four reads in order
    do_reset();
    do_write(32'h07020106, "t2w0");
    do_write(32'h37323136, "t2w1");
    do_write(32'hdeadbeef, "t2w2");
    do_write(32'd7216,     "t2w3");
    check_val("t2_cnt4", 32'(count), 32'd4);
    do_read(32'h07020106, "t2r0");
    do_read(32'h37323136, "t2r1");
    do_read(32'hdeadbeef, "t2r2");
    do_read(32'h00001c30, "t2r3");
    check_val("t2_cnt0", 32'(count), 32'd0);
    check_val("t2_empty", 32'(empty), 32'd1);

    // 3: sustained contention after last grant=write alternates R,W,R,W
    do_reset();
    do_write(32'h11111111, "t3a");
    do_write(32'h22222222, "t3b");
    wr_val = 1'b1; wr_data = 32'h33333333; rd_val = 1'b1;
    #1;
    gi = 0; ri = 0; n = 0;
    while (gi < 4 && n < 600) begin
      if (wr_rdy || rd_rdy) begin
        check_val("t3_excl", 32'(wr_rdy & rd_rdy), 32'd0);
        g[gi] = rd_rdy;
        gi++;
      end
      if (rd_resp_val && ri < 4) begin
        rdata[ri] = rd_resp_data;
        ri++;
      end
      @(negedge clk);
      n++;
    end
    wr_val = 1'b0; rd_val = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    check_val("t3_ngrants", gi, 32'd4);
    check_val("t3_g0_rd", 32'(g[0]), 32'd1);
    check_val("t3_g1_wr", 32'(g[1]), 32'd0);
    check_val("t3_g2_rd", 32'(g[2]), 32'd1);
    check_val("t3_g3_wr", 32'(g[3]), 32'd0);
    check_val("t3_nresp", ri, 32'd2);
    check_val("t3_rd0", rdata[0], 32'h11111111);
    check_val("t3_rd1", rdata[1], 32'h22222222);
    check_val("t3_cnt", 32'(count), 32'd2);

    // 4: fill to 64, write gated when full, read gated when empty
    do_reset();
    for (int i = 0; i < 64; i++)
      do_write(32'h5a000000 + 32'(i), $sformatf("t4w%0d", i));
    check_val("t4_full", 32'(full), 32'd1);
    check_val("t4_cnt", 32'(count), 32'd64);
    check_val("t4_empty", 32'(empty), 32'd0);
    wr_val = 1'b1; wr_data = 32'hffffffff;
    repeat (3) @(negedge clk);
    check_val("t4_wrdy_full", 32'(wr_rdy), 32'd0);
    check_val("t4_busy_full", 32'(busy), 32'd0);
    wr_val = 1'b0;
    do_read(32'h5a000000, "t4r0");
    check_val("t4_notfull", 32'(full), 32'd0);
    do_reset();
    rd_val = 1'b1;
    repeat (3) @(negedge clk);
    check_val("t4_rrdy_empty", 32'(rd_rdy), 32'd0);
    check_val("t4_busy_empty", 32'(busy), 32'd0);
    rd_val = 1'b0;

    // 5: buffer never acknowledges
    do_reset();
    ack_en = 1'b0;
    wr_val = 1'b1; wr_data = 32'h0badf00d;
    #1;
    n = 0;
    while (!wr_rdy && n < 50) begin @(negedge clk); n++; end
    check_val("t5_wrdy", 32'(wr_rdy), 32'd1);
    @(negedge clk);
    wr_val = 1'b0;
    repeat (250) @(negedge clk);
`ifdef SCAN_BUF_WDT_EN
    check_val("t5_err", 32'(err), 32'd1);
    check_val("t5_valop", 32'(buf_val_op), 32'd0);
    check_val("t5_busy", 32'(busy), 32'd0);
`else
    check_val("t5_err", 32'(err), 32'd0);
    check_val("t5_valop", 32'(buf_val_op), 32'd1);
    check_val("t5_busy", 32'(busy), 32'd1);
`endif
    check_val("t5_cnt", 32'(count), 32'd0);
    do_reset();
    ack_en = 1'b1;

    // 6: asynchronous reset while bit 10 is on sin
    wr_val = 1'b1; wr_data = 32'ha5a55a5a;
    #1;
    n = 0;
    while (!wr_rdy && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    wr_val = 1'b0;
    n = 0;
    while (!(coll && nb == 10) && n < 100) begin @(negedge clk); n++; end
    check_val("t6_bit10", nb, 32'd10);
    check_val("t6_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_write(32'hc3c3c3c3, "t6w");
    check_val("t6_cnt1", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
